aes_128_key_expander: RTL and testbench

//  Iterative FIPS-197 sec. 5.2 key schedule for AES-128, upstream of aes_128_encryptor.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_sbox.sv | 9 +
 rtl/aes_128_key_expander.sv | 65 ++++++
 tb/tb_aes_128_key_expander.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM encoding, round constants and S-box table
package aes_pkg;
  localparam int KEY_W = 128;
  localparam int NR = 10;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;
      4'd2: return 8'h02;
      4'd3: return 8'h04;
      4'd4: return 8'h08;
      4'd5: return 8'h10;
      4'd6: return 8'h20;
      4'd7: return 8'h40;
      4'd8: return 8'h80;
      4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational 8-bit AES SubBytes lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] s
);
  assign s = SBOX[x];
endmodule

// File: rtl/aes_128_key_expander.sv
// aes_128_key_expander: iterative AES-128 key schedule with an 11-entry round-key file
module aes_128_key_expander
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);
  state_t state, state_nxt;
  logic [3:0] rnd;
  logic [KEY_W-1:0] rk [NR+1];
  logic [KEY_W-1:0] prev, nxt;
  logic [31:0] rot, sub, t, n0, n1, n2, n3;
  logic accept;
  assign key_ready = state != EXPAND;
  assign accept = key_valid && key_ready;
  assign rot = {prev[23:0], prev[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.x(rot[8*g +: 8]), .s(sub[8*g +: 8]));
  end
  assign t = sub ^ {rcon(rnd), 24'h0};
  assign n0 = prev[127:96] ^ t;
  assign n1 = prev[95:64] ^ n0;
  assign n2 = prev[63:32] ^ n1;
  assign n3 = prev[31:0] ^ n2;
  assign nxt = {n0, n1, n2, n3};
  // select the previous round key for expansion and the key addressed by rd_idx
  always_comb begin
    prev = '0;
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rnd == i[3:0] + 4'd1) prev = rk[i];
      if (rd_idx == i[3:0]) rd_key = rk[i];
    end
  end
  // next state: accept starts expansion, writing round key NR finishes it
  always_comb begin
    state_nxt = accept ? EXPAND : (state == EXPAND && rnd == 4'(NR)) ? DONE : state;
  end
  // state, round counter and round-key file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd <= '0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rk[0] <= key_in;
        rnd <= 4'd1;
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        for (int i = 1; i <= NR; i++) if (rnd == i[3:0]) rk[i] <= nxt;
        rnd <= rnd == 4'(NR) ? rnd : rnd + 4'd1;
        keys_valid <= rnd == 4'(NR);
      end
    end
  end
endmodule

// File: tb/tb_aes_128_key_expander.sv
// tb_aes_128_key_expander: randomized self-checking bench with a word-level key schedule model
module tb_aes_128_key_expander;
  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0] rd_idx = '0;
  logic key_ready, keys_valid;
  logic [127:0] rd_key;
  int checks = 0, errors = 0;
  logic [127:0] ref_rk [11];
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_128_key_expander dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .keys_valid(keys_valid), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int x = 1; x < 256; x++) if (b != 0 && gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword_ref(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  // key schedule over the 44-word array w[i] = w[i-4] ^ temp
  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subword_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!keys_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic sweep(input string name);
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      exp = i < 11 ? ref_rk[i] : 128'h0;
      checks++;
      if (rd_key !== exp) begin
        errors++;
        $display("FAIL %s rd_idx=%0d got %h want %h", name, i, rd_key, exp);
      end
    end
  endtask

  task automatic read_chk(input string name, input int idx, input logic [127:0] exp);
    rd_idx = 4'(idx);
    #1;
    checks++;
    if (rd_key !== exp) begin
      errors++;
      $display("FAIL %s rd_key[%0d] got %h want %h", name, idx, rd_key, exp);
    end
  endtask

  task automatic bit_chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    bit_chk("reset_key_ready", key_ready, 1'b1);
    bit_chk("reset_keys_valid", keys_valid, 1'b0);
    for (int r = 0; r < 11; r++) ref_rk[r] = '0;
    sweep("reset_rd_key");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expand_and_check(input string name, input logic [127:0] k);
    int n;
    compute_ref(k);
    start(k);
    bit_chk({name, "_valid_drop"}, keys_valid, 1'b0);
    bit_chk({name, "_ready_low"}, key_ready, 1'b0);
    read_chk({name, "_rk0_at_accept"}, 0, k);
    wait_done(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL %s_latency edges_after_accept got %0d want 10", name, n);
    end
    bit_chk({name, "_ready_done"}, key_ready, 1'b1);
    sweep(name);
  endtask

  task automatic test_fips();
    expand_and_check("fips", FIPS_KEY);
    read_chk("fips_rk1_const", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_chk("fips_rk10_const", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  task automatic test_hold_valid();
    int n = 0, busy = 0;
    compute_ref(FIPS_KEY);
    @(negedge clk);
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_in = rand128();
    while (!keys_valid && n < 30) begin
      if (!key_ready) busy++;
      @(posedge clk);
      #1;
      n++;
    end
    key_valid = 1'b0;
    checks++;
    if (busy != 10) begin
      errors++;
      $display("FAIL hold_ready_low cycles got %0d want 10", busy);
    end
    sweep("hold");
  endtask

  task automatic test_rekey_zero();
    expand_and_check("zero", 128'h0);
    read_chk("zero_rk1_const", 1, 128'h62636363626363636263636362636363);
    read_chk("zero_rk10_const", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
  endtask

  task automatic test_abort();
    start(rand128());
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    bit_chk("abort_keys_valid", keys_valid, 1'b0);
    bit_chk("abort_key_ready", key_ready, 1'b1);
    read_chk("abort_rk0", 0, 128'h0);
    read_chk("abort_rk3", 3, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    bit_chk("abort_idle_ready", key_ready, 1'b1);
    bit_chk("abort_stays_invalid", keys_valid, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) expand_and_check("random", rand128());
  endtask

  initial begin
    test_reset();
    test_fips();
    test_hold_valid();
    test_rekey_zero();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
